salsa_round_unit: RTL and testbench



---
 rtl/salsa_round_unit.sv | 105 ++++++++++
 tb/tb_salsa_round_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/salsa_round_unit.sv
// Registered Salsa20 round engine: one column or row round per cycle, 1-cycle latency.
// Optional SALSA_DOUBLE_ROUND_EN adds a dbl input that performs column+row in one cycle.
module salsa_round_unit (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         odd,
  input  logic [511:0] d_in,
`ifdef SALSA_DOUBLE_ROUND_EN
  input  logic         dbl,
`endif
  output logic         out_valid,
  output logic [511:0] d_out
);

  logic [511:0] d_out_d, d_out_q;
  logic         out_valid_d, out_valid_q;
  logic [511:0] col_res, row_res, round_res;

  // Returns {a', b', c', d'}; rotations are written as fixed concatenations.
  function automatic logic [127:0] quarter_round(input logic [31:0] a, input logic [31:0] b,
                                                 input logic [31:0] c, input logic [31:0] d);
    logic [31:0] t, bn, cn, dn, an;
    t  = a + d;
    bn = b ^ {t[24:0], t[31:25]};
    t  = bn + a;
    cn = c ^ {t[22:0], t[31:23]};
    t  = cn + bn;
    dn = d ^ {t[18:0], t[31:19]};
    t  = dn + cn;
    an = a ^ {t[13:0], t[31:14]};
    return {an, bn, cn, dn};
  endfunction

  function automatic logic [511:0] column_round(input logic [511:0] s);
    logic [31:0]  w [16];
    logic [31:0]  r [16];
    logic [511:0] o;
    for (int i = 0; i < 16; i++) begin
      w[i] = s[32*i +: 32];
    end
    {r[0],  r[4],  r[8],  r[12]} = quarter_round(w[0],  w[4],  w[8],  w[12]);
    {r[5],  r[9],  r[13], r[1]}  = quarter_round(w[5],  w[9],  w[13], w[1]);
    {r[10], r[14], r[2],  r[6]}  = quarter_round(w[10], w[14], w[2],  w[6]);
    {r[15], r[3],  r[7],  r[11]} = quarter_round(w[15], w[3],  w[7],  w[11]);
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[32*i +: 32] = r[i];
    end
    return o;
  endfunction

  function automatic logic [511:0] row_round(input logic [511:0] s);
    logic [31:0]  w [16];
    logic [31:0]  r [16];
    logic [511:0] o;
    for (int i = 0; i < 16; i++) begin
      w[i] = s[32*i +: 32];
    end
    {r[0],  r[1],  r[2],  r[3]}  = quarter_round(w[0],  w[1],  w[2],  w[3]);
    {r[5],  r[6],  r[7],  r[4]}  = quarter_round(w[5],  w[6],  w[7],  w[4]);
    {r[10], r[11], r[8],  r[9]}  = quarter_round(w[10], w[11], w[8],  w[9]);
    {r[15], r[12], r[13], r[14]} = quarter_round(w[15], w[12], w[13], w[14]);
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[32*i +: 32] = r[i];
    end
    return o;
  endfunction

  always_comb begin
    col_res = column_round(d_in);
`ifdef SALSA_DOUBLE_ROUND_EN
    // Row round consumes either d_in (single row round) or the column result (double round).
    row_res = row_round(dbl ? col_res : d_in);
    if (dbl) begin
      round_res = row_res;
    end else begin
      round_res = odd ? row_res : col_res;
    end
`else
    row_res   = row_round(d_in);
    round_res = odd ? row_res : col_res;
`endif
  end

  always_comb begin
    out_valid_d = in_valid;
    d_out_d     = in_valid ? round_res : d_out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      d_out_q     <= d_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign d_out     = d_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_salsa_round_unit.sv
// Self-checking bench for salsa_round_unit: directed vectors plus random states checked
// against an index-table Salsa20 reference model.
module tb_salsa_round_unit;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         odd;
  logic [511:0] d_in;
  logic         out_valid;
  logic [511:0] d_out;
`ifdef SALSA_DOUBLE_ROUND_EN
  logic         dbl;
`endif

  int tests = 0;
  int fails = 0;

  salsa_round_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .odd       (odd),
    .d_in      (d_in),
`ifdef SALSA_DOUBLE_ROUND_EN
    .dbl       (dbl),
`endif
    .out_valid (out_valid),
    .d_out     (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: quarterround slots listed as (a,b,c,d) word indices.
  int col_tab [4][4] = '{'{0, 4, 8, 12}, '{5, 9, 13, 1}, '{10, 14, 2, 6}, '{15, 3, 7, 11}};
  int row_tab [4][4] = '{'{0, 1, 2, 3}, '{5, 6, 7, 4}, '{10, 11, 8, 9}, '{15, 12, 13, 14}};

  function automatic logic [31:0] m_rotl(input logic [31:0] x, input int n);
    logic [31:0] l, r;
    l = x << n;
    r = x >> (32 - n);
    return l | r;
  endfunction

  function automatic logic [511:0] m_round(input logic [511:0] s, input bit is_row);
    logic [31:0]  w [16];
    logic [31:0]  a, b, c, d;
    int           ix [4];
    logic [511:0] o;
    for (int i = 0; i < 16; i++) w[i] = s[32*i +: 32];
    for (int q = 0; q < 4; q++) begin
      for (int j = 0; j < 4; j++) ix[j] = is_row ? row_tab[q][j] : col_tab[q][j];
      a = w[ix[0]]; b = w[ix[1]]; c = w[ix[2]]; d = w[ix[3]];
      b = b ^ m_rotl(a + d, 7);
      c = c ^ m_rotl(b + a, 9);
      d = d ^ m_rotl(c + b, 13);
      a = a ^ m_rotl(d + c, 18);
      w[ix[0]] = a; w[ix[1]] = b; w[ix[2]] = c; w[ix[3]] = d;
    end
    for (int i = 0; i < 16; i++) o[32*i +: 32] = w[i];
    return o;
  endfunction

  function automatic logic [511:0] m_hash(input logic [511:0] s);
    logic [511:0] x;
    x = s;
    for (int k = 0; k < 20; k++) x = m_round(x, k % 2 == 1);
    for (int i = 0; i < 16; i++) x[32*i +: 32] = x[32*i +: 32] + s[32*i +: 32];
    return x;
  endfunction

  function automatic logic [511:0] add_words(input logic [511:0] x, input logic [511:0] y);
    logic [511:0] o;
    for (int i = 0; i < 16; i++) o[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return o;
  endfunction

  function automatic logic [511:0] rand_state();
    logic [511:0] s;
    for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  task automatic check_state(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [511:0] orig, exp_s, held, hash_obs;
  bit           r_odd;

  initial begin
    // Reset with live inputs.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    odd      = 1'b0;
    d_in     = rand_state();
`ifdef SALSA_DOUBLE_ROUND_EN
    dbl      = 1'b0;
`endif
    #1;
    check_state("reset_dout_t0", d_out, '0);
    check_bit("reset_valid_t0", out_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      d_in = rand_state();
      odd  = i[0];
      tick();
      check_state("reset_dout_hold", d_out, '0);
      check_bit("reset_valid_hold", out_valid, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // All-zero state, column then row.
    d_in = '0; odd = 1'b0; in_valid = 1'b1;
    tick();
    check_state("zero_col", d_out, '0);
    check_bit("zero_col_valid", out_valid, 1'b1);
    odd = 1'b1;
    tick();
    check_state("zero_row", d_out, '0);

    // Directed vectors: words 0,4,8,12 = 1.
    d_in = '0;
    d_in[0 +: 32] = 32'h1; d_in[128 +: 32] = 32'h1; d_in[256 +: 32] = 32'h1;
    d_in[384 +: 32] = 32'h1;
    odd = 1'b0;
    tick();
    exp_s = '0;
    exp_s[0 +: 32] = 32'h10090288; exp_s[128 +: 32] = 32'h00000101;
    exp_s[256 +: 32] = 32'h00020401; exp_s[384 +: 32] = 32'h40a04001;
    check_state("vec_col", d_out, exp_s);
    odd = 1'b1;
    tick();
    exp_s = {32'h88000100, 32'h00402000, 32'h00000200, 32'h00000001,
             32'h00000000, 32'h80040000, 32'h00002000, 32'h00000001,
             32'h00010000, 32'h00000080, 32'h00048044, 32'h20100001,
             32'h20500000, 32'h00010200, 32'h00000080, 32'h08008145};
    check_state("vec_row", d_out, exp_s);

    // Random single rounds, back-to-back.
    for (int i = 0; i < 8; i++) begin
      d_in  = rand_state();
      r_odd = 1'($urandom_range(0, 1));
      odd   = r_odd;
      exp_s = m_round(d_in, r_odd);
      tick();
      check_state(r_odd ? "rand_row" : "rand_col", d_out, exp_s);
      check_bit("rand_valid", out_valid, 1'b1);
    end

    // Hold: single pulse then five idle cycles.
    d_in  = rand_state();
    r_odd = 1'($urandom_range(0, 1));
    odd   = r_odd;
    held  = m_round(d_in, r_odd);
    tick();
    check_state("hold_first", d_out, held);
    check_bit("hold_valid_pulse", out_valid, 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d_in = rand_state();
      odd  = ~odd;
      tick();
      check_bit("hold_valid_low", out_valid, 1'b0);
      check_state("hold_dout_stable", d_out, held);
    end

    // Feedback: 20 rounds, alternating odd, then feed-forward add.
    for (int t = 0; t < 2; t++) begin
      orig     = rand_state();
      exp_s    = orig;
      d_in     = orig;
      in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
        odd   = k[0];
        exp_s = m_round(exp_s, k[0]);
        tick();
        check_state("feedback_round", d_out, exp_s);
        d_in = d_out;
      end
      hash_obs = add_words(d_out, orig);
      check_state("feedback_hash", hash_obs, m_hash(orig));
    end
    in_valid = 1'b0;
    tick();

`ifdef SALSA_DOUBLE_ROUND_EN
    // Double rounds: ten cycles must reproduce the 20-round hash; odd is ignored.
    orig     = rand_state();
    d_in     = orig;
    in_valid = 1'b1;
    dbl      = 1'b1;
    for (int k = 0; k < 10; k++) begin
      odd = 1'($urandom_range(0, 1));
      tick();
      d_in = d_out;
    end
    hash_obs = add_words(d_out, orig);
    check_state("dbl_hash", hash_obs, m_hash(orig));
    dbl      = 1'b0;
    in_valid = 1'b0;
    tick();
`endif

    // Reset mid-stream clears outputs without waiting for a clock edge.
    in_valid = 1'b1;
    d_in     = rand_state();
    odd      = 1'b0;
    tick();
    check_state("pre_reset", d_out, m_round(d_in, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    check_state("midreset_dout", d_out, '0);
    check_bit("midreset_valid", out_valid, 1'b0);
    tick();
    check_state("midreset_dout_edge", d_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    d_in  = rand_state();
    odd   = 1'b1;
    exp_s = m_round(d_in, 1'b1);
    tick();
    check_state("post_reset", d_out, exp_s);
    check_bit("post_reset_valid", out_valid, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
